regfile_mp: RTL

// - Multi-port successor to the single-write/dual-read 32-bit register file.
// - Provides NRD async read ports and NWR sync write ports; register 0 is hardwired to zero.
// - Adds optional write-to-read bypass and a reset/on-demand clear sequencer with a ready flag.
// - Sits between decode (read addresses) and writeback (write ports) in the processor datapath.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_rd_port.sv | 45 ++++
 rtl/regfile_mp.sv | 134 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types, default widths and the port-priority helper for the multi-port register file.
package regfile_pkg;

    typedef enum logic {CLEAR, RUN} rf_state_t;

    localparam int unsigned RF_RWIDTH    = 6;
    localparam int unsigned RF_DWIDTH    = 32;
    // Upper bound on write ports handled by the priority helper.
    localparam int unsigned RF_MAX_PORTS = 16;

    // Highest set index in hits, or -1 when no bit is set. The highest port wins.
    function automatic int hi_match(input logic [RF_MAX_PORTS-1:0] hits);
        int idx;
        idx = -1;
        for (int i = 0; i < int'(RF_MAX_PORTS); i++) begin
            if (hits[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: zero-register check, write bypass and clear gating.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned RWIDTH = RF_RWIDTH,
    parameter int unsigned DWIDTH = RF_DWIDTH,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned DEPTH = 2 ** RWIDTH
) (
    input  logic                          run,
    input  logic [RWIDTH-1:0]             ra,
    input  logic [DEPTH-1:0][DWIDTH-1:0]  mem,
    input  logic [NWR-1:0]                we,
    input  logic [NWR*RWIDTH-1:0]         wa,
    input  logic [NWR*DWIDTH-1:0]         wd,
    output logic [DWIDTH-1:0]             rd
);

    logic [RF_MAX_PORTS-1:0] hits;
    int                      sel;

    // Stored value, overridden by the highest matching write port, forced to 0 for r0 or clear.
    always_comb begin
        hits = '0;
        for (int q = 0; q < int'(NWR); q++) begin
            if (we[q] && (wa[q*RWIDTH +: RWIDTH] == ra)) begin
                hits[q] = 1'b1;
            end
        end
        sel = hi_match(hits);
        rd  = mem[ra];
        if ((BYPASS != 0) && run) begin
            for (int q = 0; q < int'(NWR); q++) begin
                if (q == sel) begin
                    rd = wd[q*DWIDTH +: DWIDTH];
                end
            end
        end
        if (!run || (ra == '0)) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD async reads, NWR sync writes, r0 hardwired to zero,
// and a clear sequencer that zeroes every entry after reset or on clr_req.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned RWIDTH = RF_RWIDTH,
    parameter int unsigned DWIDTH = RF_DWIDTH,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    input  logic [NRD*RWIDTH-1:0]   ra,
    output logic [NRD*DWIDTH-1:0]   rd,
    input  logic [NWR-1:0]          we,
    input  logic [NWR*RWIDTH-1:0]   wa,
    input  logic [NWR*DWIDTH-1:0]   wd,
    output logic                    ready
);

    localparam int unsigned       DEPTH = 2 ** RWIDTH;
    localparam logic [RWIDTH-1:0] LAST  = RWIDTH'(DEPTH - 1);

    rf_state_t                    state_q, state_d;
    logic [RWIDTH-1:0]            clr_cnt_q, clr_cnt_d;
    logic [DEPTH-1:1][DWIDTH-1:0] mem_q;
    logic [DEPTH-1:0][DWIDTH-1:0] mem_view;
    logic [DEPTH-1:1]             mem_we;
    logic [DEPTH-1:1][DWIDTH-1:0] mem_wdata;
    logic [RF_MAX_PORTS-1:0]      wr_hits;
    int                           wr_sel;
    logic                         run;

    assign run      = (state_q == RUN);
    assign ready    = run;
    // Entry 0 has no storage; it is a constant zero slot in the read view.
    assign mem_view = {mem_q, {DWIDTH{1'b0}}};

    // Clear sequencer next state: walk clr_cnt 1..DEPTH-1, then hold at the top and run.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                if (clr_cnt_q == LAST) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = RWIDTH'(1);
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Sequencer state with synchronous active-low reset; reset always restarts the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= RWIDTH'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Per-entry write decode: clear writes zero, otherwise the highest matching port wins.
    always_comb begin
        mem_we    = '0;
        mem_wdata = '0;
        wr_hits   = '0;
        wr_sel    = -1;
        if (!run) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (clr_cnt_q == RWIDTH'(i)) begin
                    mem_we[i] = 1'b1;
                end
            end
        end else if (!clr_req) begin
            // User writes in the clr_req cycle are discarded.
            for (int i = 1; i < int'(DEPTH); i++) begin
                wr_hits = '0;
                for (int q = 0; q < int'(NWR); q++) begin
                    if (we[q] && (wa[q*RWIDTH +: RWIDTH] == RWIDTH'(i))) begin
                        wr_hits[q] = 1'b1;
                    end
                end
                wr_sel    = hi_match(wr_hits);
                mem_we[i] = (wr_sel >= 0);
                for (int q = 0; q < int'(NWR); q++) begin
                    if (q == wr_sel) begin
                        mem_wdata[i] = wd[q*DWIDTH +: DWIDTH];
                    end
                end
            end
        end
    end

    // Storage for entries 1..DEPTH-1; contents before the first clear completes are don't-care.
    always_ff @(posedge clk) begin
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (mem_we[i]) begin
                mem_q[i] <= mem_wdata[i];
            end
        end
    end

    for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
        regfile_rd_port #(
            .RWIDTH (RWIDTH),
            .DWIDTH (DWIDTH),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_rd (
            .run (run),
            .ra  (ra[p*RWIDTH +: RWIDTH]),
            .mem (mem_view),
            .we  (we),
            .wa  (wa),
            .wd  (wd),
            .rd  (rd[p*DWIDTH +: DWIDTH])
        );
    end

endmodule
